// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - result buffer behind the adder with show-ahead ready/valid output
// Tracks a sticky drop flag and a wrapping running sum of every accepted result.
module adder_result_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_c,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [ACC_W-1:0]           sum_acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO still accepts when drained.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sum_acc  <= '0;
      // Clearing storage makes out_data read 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_c;
        wr_ptr      <= wr_ptr + 1'b1;
        sum_acc     <= sum_acc + ACC_W'(in_c);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb/tb_adder_result_fifo.sv - randomized and directed bench for adder_result_fifo
// Reference model is a plain queue with a sticky drop flag and a modular sum.
module tb_adder_result_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [4:0] in_c;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic [11:0] sum_acc;

  int checks = 0;
  int errors = 0;
  int q[$];
  bit m_ovf;
  int m_sum;

  adder_result_fifo #(.DATA_W(5), .DEPTH(4), .ACC_W(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_c(in_c),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .sum_acc(sum_acc)
  );

  always #5 clk = ~clk;

  task automatic cycle(input bit iv, input int c, input bit ordy, input bit rst, output bit pushed);
    bit pop;
    reset = rst; in_valid = iv; in_c = 5'(c); out_ready = ordy;
    pushed = 1'b0;
    if (rst) begin
      q.delete(); m_ovf = 1'b0; m_sum = 0;
    end else begin
      pop = (q.size() > 0) && ordy;
      pushed = iv && ((q.size() < 4) || pop);
      if (iv && !pushed) m_ovf = 1'b1;
      if (pop) void'(q.pop_front());
      if (pushed) begin
        q.push_back(c);
        m_sum = (m_sum + c) % 4096;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit p;
    cycle(1, 17, 1, 1, p);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%0b full=%0b expected 1 0", empty, full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0 || sum_acc !== 12'd0) begin errors++; $display("FAIL reset_ovf_sum: got %0b %0d expected 0 0", overflow, sum_acc); end
    checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
  endtask

  task automatic test_pass_through();
    bit p;
    cycle(0, 0, 0, 1, p);
    cycle(1, 13, 1, 0, p);
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd13) begin errors++; $display("FAIL pass_out: got valid=%0b data=%0d expected 1 13", out_valid, out_data); end
    cycle(0, 0, 1, 0, p);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pass_empty: got %0b expected 1", empty); end
    checks++; if (sum_acc !== 12'd13) begin errors++; $display("FAIL pass_sum: got %0d expected 13", sum_acc); end
  endtask

  task automatic test_fill_overflow();
    int vals[5] = '{3, 7, 11, 2, 9};
    int exp_out[4] = '{3, 7, 11, 2};
    bit p;
    cycle(0, 0, 0, 1, p);
    for (int i = 0; i < 4; i++) cycle(1, vals[i], 0, 0, p);
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fill_full: got full=%0b ovf=%0b expected 1 0", full, overflow); end
    cycle(1, vals[4], 0, 0, p);
    checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_ovf: got ovf=%0b count=%0d expected 1 4", overflow, count); end
    checks++; if (sum_acc !== 12'd23) begin errors++; $display("FAIL fill_sum: got %0d expected 23", sum_acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 5'(exp_out[i])) begin errors++; $display("FAIL fill_drain%0d: got %0d expected %0d", i, out_data, exp_out[i]); end
      cycle(0, 0, 1, 0, p);
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL fill_end: got empty=%0b ovf=%0b expected 1 1", empty, overflow); end
  endtask

  task automatic test_full_push_pop();
    int exp_out[4] = '{2, 3, 4, 5};
    bit p;
    cycle(0, 0, 0, 1, p);
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0, p);
    cycle(1, 5, 1, 0, p);
    checks++; if (count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fullpp_state: got count=%0d ovf=%0b expected 4 0", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== 5'(exp_out[i])) begin errors++; $display("FAIL fullpp_drain%0d: got %0d expected %0d", i, out_data, exp_out[i]); end
      cycle(0, 0, 1, 0, p);
    end
  endtask

  task automatic test_wrap_backpressure();
    int rx[$];
    int idx = 0;
    int cyc = 0;
    bit p, ordy, iv, stalled;
    logic [4:0] held;
    cycle(0, 0, 0, 1, p);
    stalled = 1'b0;
    held = '0;
    while (rx.size() < 10 && cyc < 200) begin
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("FAIL wrap_stall: got valid=%0b data=%0d expected 1 %0d", out_valid, out_data, held); end
      end
      ordy = cyc[0];
      if (out_valid && ordy) rx.push_back(int'(out_data));
      stalled = out_valid && !ordy;
      held = out_data;
      iv = (idx < 10) && ((q.size() < 4) || (ordy && q.size() > 0));
      cycle(iv, idx, ordy, 0, p);
      if (p) idx++;
      cyc++;
    end
    checks++; if (rx.size() != 10) begin errors++; $display("FAIL wrap_timeout: got %0d items expected 10", rx.size()); end
    for (int i = 0; i < rx.size(); i++) begin
      checks++; if (rx[i] != i) begin errors++; $display("FAIL wrap_order%0d: got %0d expected %0d", i, rx[i], i); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %0b expected 0", overflow); end
  endtask

  task automatic test_acc_wrap();
    bit p;
    cycle(0, 0, 0, 1, p);
    for (int i = 0; i < 133; i++) cycle(1, 31, 1, 0, p);
    checks++; if (sum_acc !== 12'd27) begin errors++; $display("FAIL acc_wrap: got %0d expected 27", sum_acc); end
    checks++; if (overflow !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL acc_state: got ovf=%0b count=%0d expected 0 1", overflow, count); end
  endtask

  task automatic test_reset_mid();
    bit p;
    cycle(0, 0, 0, 1, p);
    for (int i = 0; i < 5; i++) cycle(1, 20 + i, 0, 0, p);
    cycle(0, 0, 1, 0, p);
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL midrst_pre: got count=%0d ovf=%0b expected 3 1", count, overflow); end
    cycle(1, 9, 0, 1, p);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_count: got count=%0d valid=%0b expected 0 0", count, out_valid); end
    checks++; if (overflow !== 1'b0 || sum_acc !== 12'd0) begin errors++; $display("FAIL midrst_ovf_sum: got %0b %0d expected 0 0", overflow, sum_acc); end
  endtask

  task automatic test_random();
    bit p;
    cycle(0, 0, 0, 1, p);
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), bit'($urandom_range(0, 2) != 0),
            $urandom_range(0, 63) == 0, p);
      checks++; if (int'(count) != q.size() || out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_count@%0d: got count=%0d valid=%0b expected %0d", i, count, out_valid, q.size()); end
      if (q.size() > 0) begin
        checks++; if (out_data !== 5'(q[0])) begin errors++; $display("FAIL rand_data@%0d: got %0d expected %0d", i, out_data, q[0]); end
      end
      checks++; if (full !== (q.size() == 4) || empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_flags@%0d: got full=%0b empty=%0b size %0d", i, full, empty, q.size()); end
      checks++; if (overflow !== m_ovf || int'(sum_acc) != m_sum) begin errors++; $display("FAIL rand_ovf_sum@%0d: got %0b %0d expected %0b %0d", i, overflow, sum_acc, m_ovf, m_sum); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_c = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_backpressure();
    test_acc_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
